// File: rtl/bit_demux32_collector.sv
// bit_demux32_collector: 1-to-WIDTH bit demultiplexer that assembles a serial bit stream into a word
// Ports:
//   clock_i      system clock, rising edge
//   clear_i      asynchronous active-low reset
//   d_i          serial data bit
//   s_i          bit select for direct write, start index for auto-collect
//   load_i       direct write word[s_i] <= d_i (IDLE only)
//   start_i      begin auto-collect at index s_i (IDLE only, wins over load_i)
//   bit_valid_i  d_i is valid this cycle (COLLECT)
//   out_ready_i  consumer accepts the held word
//   word_o       assembled word
//   out_valid_o  word complete, awaiting acceptance (HOLD)
//   busy_o       high in COLLECT or HOLD
//   idx_o        current write index
//   count_o      bits collected in the current sequence, 0..WIDTH
module bit_demux32_collector #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 5
) (
    input  logic             clock_i,
    input  logic             clear_i,
    input  logic             d_i,
    input  logic [SEL_W-1:0] s_i,
    input  logic             load_i,
    input  logic             start_i,
    input  logic             bit_valid_i,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] word_o,
    output logic             out_valid_o,
    output logic             busy_o,
    output logic [SEL_W-1:0] idx_o,
    output logic [SEL_W:0]   count_o
);
    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [SEL_W:0]   count_q, count_d;

    always_ff @(posedge clock_i or negedge clear_i) begin
        if (!clear_i) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    idx_d   = s_i;
                    count_d = '0;
                    state_d = COLLECT;
                end else if (load_i) begin
                    word_d[s_i] = d_i;
                    idx_d       = s_i;
                end
            end
            COLLECT: begin
                if (bit_valid_i) begin
                    word_d[idx_q] = d_i;
                    // index wraps naturally through the SEL_W-bit width
                    idx_d         = idx_q + SEL_W'(1);
                    count_d       = count_q + (SEL_W+1)'(1);
                    if (count_q == (SEL_W+1)'(WIDTH-1)) state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign word_o      = word_q;
    assign idx_o       = idx_q;
    assign count_o     = count_q;
    // out_valid is exactly the HOLD state, so clear drops it with no edge
    assign out_valid_o = (state_q == HOLD);
    assign busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_bit_demux32_collector.sv
// tb_bit_demux32_collector: randomized self-checking bench against a word-level reference model
module tb_bit_demux32_collector;
    logic        clock_i = 1'b0;
    logic        clear_i = 1'b1;
    logic        d_i = 1'b0;
    logic [4:0]  s_i = '0;
    logic        load_i = 1'b0;
    logic        start_i = 1'b0;
    logic        bit_valid_i = 1'b0;
    logic        out_ready_i = 1'b0;
    logic [31:0] word_o;
    logic        out_valid_o;
    logic        busy_o;
    logic [4:0]  idx_o;
    logic [5:0]  count_o;

    int total = 0;
    int bad = 0;
    logic [31:0] mw = '0;

    bit_demux32_collector #(.WIDTH(32), .SEL_W(5)) dut (
        .clock_i(clock_i), .clear_i(clear_i), .d_i(d_i), .s_i(s_i), .load_i(load_i),
        .start_i(start_i), .bit_valid_i(bit_valid_i), .out_ready_i(out_ready_i),
        .word_o(word_o), .out_valid_o(out_valid_o), .busy_o(busy_o), .idx_o(idx_o), .count_o(count_o)
    );

    always #5 clock_i = ~clock_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // bit i of the stream lands at word position (start + i) mod 32
    function automatic logic [31:0] place(input logic [31:0] w, input logic [4:0] st, input logic [31:0] bits);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < 32; i++) r[(int'(st) + i) % 32] = bits[i];
        return r;
    endfunction

    // drives 32 accepted bits, optionally preceding each with a gap cycle that also carries junk load requests
    task automatic feed(input logic [31:0] bits, input bit gaps, input bit ld, output int cycles, output int early);
        cycles = 0;
        early = 0;
        for (int i = 0; i < 32; i++) begin
            if (gaps) begin
                bit_valid_i = 1'b0; d_i = 1'b0; load_i = ld; s_i = 5'($urandom);
                tick(); cycles++;
                if (out_valid_o) early++;
            end
            bit_valid_i = 1'b1; d_i = bits[i]; load_i = ld; s_i = 5'($urandom);
            tick(); cycles++;
            if (i < 31 && out_valid_o) early++;
        end
        bit_valid_i = 1'b0; load_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] bits;
        int cyc, early;
        #2 clear_i = 1'b0;
        #1;
        total++; if (word_o !== 32'h0) begin bad++; $display("FAIL reset_word got=%h want=%h", word_o, 32'h0); end
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        total++; if (idx_o !== 5'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", idx_o); end
        total++; if (count_o !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count_o); end
        tick();
        clear_i = 1'b1;
        tick();
        s_i = 5'd3; start_i = 1'b1; tick(); start_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bit_valid_i = 1'b1; d_i = 1'b1; tick();
        end
        bit_valid_i = 1'b0;
        total++; if (count_o !== 6'd10) begin bad++; $display("FAIL mid_count got=%0d want=10", count_o); end
        total++; if (word_o !== 32'h0000_1FF8) begin bad++; $display("FAIL mid_word got=%h want=%h", word_o, 32'h0000_1FF8); end
        #3 clear_i = 1'b0;
        #1;
        total++; if (word_o !== 32'h0) begin bad++; $display("FAIL async_word got=%h want=0", word_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL async_busy got=%b want=0", busy_o); end
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL async_valid got=%b want=0", out_valid_o); end
        total++; if (idx_o !== 5'd0) begin bad++; $display("FAIL async_idx got=%0d want=0", idx_o); end
        total++; if (count_o !== 6'd0) begin bad++; $display("FAIL async_count got=%0d want=0", count_o); end
        clear_i = 1'b1;
        mw = '0;
        tick();
        s_i = 5'd7; start_i = 1'b1; tick(); start_i = 1'b0;
        total++; if (busy_o !== 1'b1 || idx_o !== 5'd7 || count_o !== 6'd0) begin bad++; $display("FAIL post_reset_start got busy=%b idx=%0d count=%0d want 1/7/0", busy_o, idx_o, count_o); end
        bits = $urandom;
        feed(bits, 1'b0, 1'b0, cyc, early);
        mw = place(mw, 5'd7, bits);
        total++; if (out_valid_o !== 1'b1 || early != 0) begin bad++; $display("FAIL post_reset_valid got=%b early=%0d want 1/0", out_valid_o, early); end
        total++; if (word_o !== mw) begin bad++; $display("FAIL post_reset_word got=%h want=%h", word_o, mw); end
        out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
        total++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || count_o !== 6'd0) begin bad++; $display("FAIL post_reset_accept got valid=%b busy=%b count=%0d want 0/0/0", out_valid_o, busy_o, count_o); end
    endtask

    task automatic test_direct();
        logic [4:0] ls;
        logic ld;
        #3 clear_i = 1'b0;
        #1 clear_i = 1'b1;
        mw = '0;
        tick();
        load_i = 1'b1;
        s_i = 5'd0;  d_i = 1'b1; tick();
        s_i = 5'd31; d_i = 1'b1; tick();
        s_i = 5'd4;  d_i = 1'b1; tick();
        load_i = 1'b0;
        total++; if (word_o !== 32'h8000_0011) begin bad++; $display("FAIL direct_word got=%h want=%h", word_o, 32'h8000_0011); end
        total++; if (idx_o !== 5'd4) begin bad++; $display("FAIL direct_idx got=%0d want=4", idx_o); end
        load_i = 1'b1; s_i = 5'd4; d_i = 1'b0; tick(); load_i = 1'b0;
        total++; if (word_o !== 32'h8000_0001) begin bad++; $display("FAIL direct_clear got=%h want=%h", word_o, 32'h8000_0001); end
        mw = 32'h8000_0001;
        for (int i = 0; i < 16; i++) begin
            ls = 5'($urandom); ld = 1'($urandom);
            load_i = 1'b1; s_i = ls; d_i = ld; tick(); load_i = 1'b0;
            mw[ls] = ld;
            total++; if (word_o !== mw || idx_o !== ls || busy_o !== 1'b0) begin bad++; $display("FAIL direct_rand got word=%h idx=%0d busy=%b want %h/%0d/0", word_o, idx_o, busy_o, mw, ls); end
        end
    endtask

    task automatic test_auto0();
        int cyc, early;
        s_i = 5'd0; start_i = 1'b1; tick(); start_i = 1'b0;
        feed(32'h1234_5678, 1'b0, 1'b0, cyc, early);
        mw = 32'h1234_5678;
        total++; if (out_valid_o !== 1'b1 || early != 0 || cyc != 32) begin bad++; $display("FAIL auto0_valid got=%b early=%0d cycles=%0d want 1/0/32", out_valid_o, early, cyc); end
        total++; if (word_o !== mw) begin bad++; $display("FAIL auto0_word got=%h want=%h", word_o, mw); end
        total++; if (idx_o !== 5'd0 || count_o !== 6'd32 || busy_o !== 1'b1) begin bad++; $display("FAIL auto0_state got idx=%0d count=%0d busy=%b want 0/32/1", idx_o, count_o, busy_o); end
        for (int i = 0; i < 5; i++) begin
            bit_valid_i = 1'b1; d_i = 1'($urandom); tick();
            total++; if (out_valid_o !== 1'b1 || word_o !== mw || count_o !== 6'd32 || idx_o !== 5'd0) begin bad++; $display("FAIL auto0_hold got valid=%b word=%h count=%0d idx=%0d", out_valid_o, word_o, count_o, idx_o); end
        end
        bit_valid_i = 1'b0;
        out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
        total++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || count_o !== 6'd0 || word_o !== mw) begin bad++; $display("FAIL auto0_accept got valid=%b busy=%b count=%0d word=%h", out_valid_o, busy_o, count_o, word_o); end
    endtask

    task automatic test_wrap();
        logic [31:0] bits;
        logic [4:0] ei;
        int wrong;
        bits = 32'h0000_FFFF;
        wrong = 0;
        s_i = 5'd16; start_i = 1'b1; tick(); start_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bit_valid_i = 1'b1; d_i = bits[i]; tick();
            ei = 5'((16 + i + 1) % 32);
            if (idx_o !== ei || count_o !== 6'(i + 1)) wrong++;
        end
        bit_valid_i = 1'b0;
        mw = place(mw, 5'd16, bits);
        total++; if (wrong != 0) begin bad++; $display("FAIL wrap_trace got %0d wrong idx/count steps want 0", wrong); end
        total++; if (word_o !== 32'hFFFF_0000 || word_o !== mw) begin bad++; $display("FAIL wrap_word got=%h want=%h", word_o, mw); end
        total++; if (idx_o !== 5'd16 || out_valid_o !== 1'b1) begin bad++; $display("FAIL wrap_end got idx=%0d valid=%b want 16/1", idx_o, out_valid_o); end
        out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
    endtask

    task automatic test_gaps();
        int cyc, early;
        load_i = 1'b1; s_i = 5'd9; d_i = 1'b0; tick(); load_i = 1'b0;
        s_i = 5'd0; start_i = 1'b1; tick(); start_i = 1'b0;
        feed(32'hFFFF_FFFF, 1'b1, 1'b1, cyc, early);
        mw = 32'hFFFF_FFFF;
        total++; if (word_o !== mw) begin bad++; $display("FAIL gaps_word got=%h want=%h", word_o, mw); end
        total++; if (out_valid_o !== 1'b1 || early != 0 || cyc != 64) begin bad++; $display("FAIL gaps_valid got=%b early=%0d cycles=%0d want 1/0/64", out_valid_o, early, cyc); end
        total++; if (idx_o !== 5'd0 || count_o !== 6'd32) begin bad++; $display("FAIL gaps_state got idx=%0d count=%0d want 0/32", idx_o, count_o); end
        out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [31:0] bits;
        int cyc, early;
        load_i = 1'b1; s_i = 5'd8; d_i = 1'b0; tick(); load_i = 1'b0;
        mw[8] = 1'b0;
        out_ready_i = 1'b1;
        start_i = 1'b1; load_i = 1'b1; s_i = 5'd8; d_i = 1'b1; tick(); start_i = 1'b0; load_i = 1'b0;
        total++; if (busy_o !== 1'b1 || idx_o !== 5'd8 || count_o !== 6'd0) begin bad++; $display("FAIL simul_start got busy=%b idx=%0d count=%0d want 1/8/0", busy_o, idx_o, count_o); end
        total++; if (word_o !== mw) begin bad++; $display("FAIL simul_word_kept got=%h want=%h", word_o, mw); end
        bits = $urandom;
        feed(bits, 1'b0, 1'b0, cyc, early);
        mw = place(mw, 5'd8, bits);
        total++; if (out_valid_o !== 1'b1 || word_o !== mw || early != 0) begin bad++; $display("FAIL simul_pulse got valid=%b word=%h early=%0d want 1/%h/0", out_valid_o, word_o, early, mw); end
        tick();
        total++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL simul_pulse_end got valid=%b busy=%b want 0/0", out_valid_o, busy_o); end
        out_ready_i = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] bits;
        logic [4:0] st, ls;
        logic ld;
        bit gaps;
        int cyc, early, hold;
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 3; k++) begin
                ls = 5'($urandom); ld = 1'($urandom);
                load_i = 1'b1; s_i = ls; d_i = ld; tick(); load_i = 1'b0;
                mw[ls] = ld;
            end
            total++; if (word_o !== mw) begin bad++; $display("FAIL rand_load got=%h want=%h", word_o, mw); end
            st = 5'($urandom); bits = $urandom; gaps = 1'($urandom);
            s_i = st; start_i = 1'b1; tick(); start_i = 1'b0;
            feed(bits, gaps, 1'($urandom), cyc, early);
            mw = place(mw, st, bits);
            total++; if (word_o !== mw || out_valid_o !== 1'b1 || early != 0 || idx_o !== st || count_o !== 6'd32) begin bad++; $display("FAIL rand_collect got word=%h valid=%b early=%0d idx=%0d count=%0d want %h/1/0/%0d/32", word_o, out_valid_o, early, idx_o, count_o, mw, st); end
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) tick();
            total++; if (out_valid_o !== 1'b1 || word_o !== mw) begin bad++; $display("FAIL rand_hold got valid=%b word=%h want 1/%h", out_valid_o, word_o, mw); end
            out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
            total++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || count_o !== 6'd0) begin bad++; $display("FAIL rand_accept got valid=%b busy=%b count=%0d want 0/0/0", out_valid_o, busy_o, count_o); end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_auto0();
        test_wrap();
        test_gaps();
        test_simultaneous();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
